periodic_timestamp_source: RTL

Produces a stream of timestamped tick events at a programmable cycle period. It is the synthesizable upstream feeder for a downstream display/logging stage. A free-running time counter is sampled every PERIOD enabled cycles. Each sample is buffered in a small FIFO and handed off over a valid/ready interface. After MAX_EVENTS events have been generated and drained, the block asserts a sticky done, which is the hardware equivalent of a simulation finish.

---
 rtl/periodic_timestamp_source.sv | 132 +++++++++++++
 1 files changed

// File: rtl/periodic_timestamp_source.sv
// Periodic timestamp event source: samples a free-running time counter
// every PERIOD enabled cycles into a small FIFO with a valid/ready output.
module periodic_timestamp_source #(
  parameter int TIME_W     = 32,
  parameter int PERIOD     = 1,
  parameter int MAX_EVENTS = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TIME_W-1:0] out_time,
  output logic              done,
  output logic [DROP_W-1:0] drop_count,
  output logic              busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = AW + 1;
  localparam int EV_W = $clog2(MAX_EVENTS + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } gen_state_e;

  gen_state_e        state_q, state_d;
  logic [TIME_W-1:0] time_cnt_q, time_cnt_d;
  logic [15:0]       phase_q, phase_d;
  logic [EV_W-1:0]   ev_cnt_q, ev_cnt_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [TIME_W-1:0] mem_q [FIFO_DEPTH];
  logic [TIME_W-1:0] mem_d [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic fifo_empty_d;
  logic at_end;
  logic fire;
  logic last;
  logic pop;
  logic push;
  logic drop;

  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign at_end = (phase_q == 16'(PERIOD - 1));
  assign fire   = enable && busy && at_end;
  assign last   = fire && (ev_cnt_q == EV_W'(MAX_EVENTS - 1));

  assign out_valid = !fifo_empty && !done;
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes the event when the head leaves this cycle
  assign push      = fire && (!fifo_full || pop);
  assign drop      = fire && !push;

  assign out_time   = mem_q[rd_ptr_q[AW-1:0]];
  assign drop_count = drop_q;

  always_comb begin
    time_cnt_d   = time_cnt_q;
    phase_d      = phase_q;
    ev_cnt_d     = ev_cnt_q;
    drop_d       = drop_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    state_d      = state_q;
    fifo_empty_d = 1'b0;

    if (!done) time_cnt_d = time_cnt_q + TIME_W'(1);

    if (enable && busy) phase_d = at_end ? 16'd0 : phase_q + 16'd1;

    if (fire) ev_cnt_d = ev_cnt_q + EV_W'(1);

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = time_cnt_q;
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    if (drop && (drop_q != {DROP_W{1'b1}})) drop_d = drop_q + DROP_W'(1);

    fifo_empty_d = (wr_ptr_d == rd_ptr_d);

    case (state_q)
      S_RUN: begin
        if (last) state_d = fifo_empty_d ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty_d) state_d = S_DONE;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      time_cnt_q <= '0;
      phase_q    <= '0;
      ev_cnt_q   <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      time_cnt_q <= time_cnt_d;
      phase_q    <= phase_d;
      ev_cnt_q   <= ev_cnt_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
    end
  end

endmodule
